issue_queue_age: RTL and testbench
==================================

// Module: issue_queue_age
// PURPOSE
//  Parametrised age-ordered issue queue for the out-of-order backend, placed between rename/dispatch and the ALU cluster.
//  Allocates its own entries for up to ENQ_W instructions/cycle and snoops CDB_W result buses to wake operands.
//  Issues up to ISS_W ready instructions/cycle, oldest first; supports full flush.
// PARAMETERS
//  DEPTH   8   entries (>= ENQ_W, >= ISS_W)
//  DATA_W  32  operand width
//  TAG_W   6   physical/ROB tag width
//  OP_W    32  opaque micro-op payload width
//  CDB_W   4   result broadcast lanes
//  ENQ_W   2   enqueue lanes/cycle
//  ISS_W   2   issue ports/cycle
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  flush        in   1                  kill all entries
//  enq_valid    in   ENQ_W              per-lane enqueue request
//  enq_ready    out  1                  free_count >= ENQ_W
//  enq_op/enq_dst in OP_W/TAG_W x ENQ_W   payload, destination tag
//  enq_v1,v2    in   DATA_W x ENQ_W     operand values
//  enq_q1,q2    in   TAG_W x ENQ_W      producer tags
//  enq_r1,r2    in   1 x ENQ_W          operand already valid
//  cdb_valid    in   CDB_W              broadcast valid
//  cdb_tag      in   TAG_W x CDB_W      broadcast tag
//  cdb_value    in   DATA_W x CDB_W     broadcast data
//  iss_valid    out  ISS_W              port holds a ready entry
//  iss_ready    in   ISS_W              FU accepts port this cycle
//  iss_op/iss_dst out OP_W/TAG_W x ISS_W  selected payload, destination tag
//  iss_v1,v2    out  DATA_W x ISS_W     selected operands
//  free_count   out  $clog2(DEPTH+1)    unoccupied entries
// BEHAVIOUR
//  Reset: all entries invalid; iss_valid=0, enq_ready=1, free_count=DEPTH; age matrix cleared. Payload regs are not reset.
//  Enqueue: accepted only when enq_ready=1 (sampled pre-edge). If enq_ready=0, all lanes are dropped; the upstream stage must hold.
//  Active lanes take the lowest-index free entries in lane order. Entries become valid at the next edge.
//  Age: per-entry age matrix. A new entry is younger than every valid entry; a lower enq lane is older than a higher lane.
//  Forwarding at enqueue: if enq_rX=0 and a CDB lane with matching tag is valid that cycle, latch cdb_value and set rX=1.
//  Wakeup: a valid entry with rX=0 captures cdb_value on a tag match and sets rX=1.
//  Duplicate CDB tags in one cycle are illegal; if they occur, the highest-index lane wins.
//  Ready = valid & r1 & r2 (registered state). A wakeup makes the entry issuable in the next cycle, not the same one.
//  Select (combinational from current state): port 0 = oldest ready entry, port p = oldest ready entry not chosen by ports 0..p-1.
//  iss_valid[p]=0 if no candidate remains. Selection ignores iss_ready.
//  Issue: an entry is freed at the edge where iss_valid[p]&iss_ready[p]=1. With iss_ready[p]=0 the entry stays and is re-selected.
//  An entry freed in cycle N can be reallocated in N+1; enq_ready/free_count do not count same-cycle frees.
//  Flush: all entries become invalid at the next edge; it overrides same-cycle enqueue and issue (issue handshakes during flush are still counted by the FU; the queue simply empties).
//  free_count = DEPTH - popcount(valid); updates one cycle after enqueue/issue/flush.
//  Full (free_count < ENQ_W): enq_ready=0. Empty: iss_valid all 0.
//  An asynchronous reset mid-operation returns the queue to the reset state immediately.
// TESTING
//  1. Reset -> free_count=8, enq_ready=1, iss_valid=00.
//  2. Enq 2 ready ops A (lane0), B (lane1) -> next cycle iss_valid=11; port0=A, port1=B; both iss_ready=1 -> free_count back to 8.
//  3. Enq C with q1=5, r1=0, while cdb tag 5 (value 0xDEAD) is valid the same cycle -> C issues next cycle with v1=0xDEAD.
//  4. Stored D waiting on tag 9; CDB broadcasts tag 9 in cycle N -> iss_valid in N+1, not N; v2 equals the broadcast value.
//  5. Fill to 7 entries -> enq_ready=0; enq_valid ignored, contents unchanged. Issue 1 -> enq_ready=1 one cycle later.
//  6. 3 ready entries, iss_ready=00 for 2 cycles -> the same two oldest stay selected. Flush with enqueue -> free_count=8, iss_valid=00.

Source files
------------

// File: rtl/issue_queue_age.sv
// Age-matrix issue queue between dispatch and the ALU cluster.
// Wakes operands from the CDB and issues the oldest ready entries first.
module issue_queue_age #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 32,
  parameter int CDB_W  = 4,
  parameter int ENQ_W  = 2,
  parameter int ISS_W  = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic [ENQ_W-1:0]        i_enq_valid,
  output logic                    o_enq_ready,
  input  logic [ENQ_W*OP_W-1:0]   i_enq_op,
  input  logic [ENQ_W*TAG_W-1:0]  i_enq_dst,
  input  logic [ENQ_W*DATA_W-1:0] i_enq_v1,
  input  logic [ENQ_W*DATA_W-1:0] i_enq_v2,
  input  logic [ENQ_W*TAG_W-1:0]  i_enq_q1,
  input  logic [ENQ_W*TAG_W-1:0]  i_enq_q2,
  input  logic [ENQ_W-1:0]        i_enq_r1,
  input  logic [ENQ_W-1:0]        i_enq_r2,
  input  logic [CDB_W-1:0]        i_cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]  i_cdb_tag,
  input  logic [CDB_W*DATA_W-1:0] i_cdb_value,
  output logic [ISS_W-1:0]        o_iss_valid,
  input  logic [ISS_W-1:0]        i_iss_ready,
  output logic [ISS_W*OP_W-1:0]   o_iss_op,
  output logic [ISS_W*TAG_W-1:0]  o_iss_dst,
  output logic [ISS_W*DATA_W-1:0] o_iss_v1,
  output logic [ISS_W*DATA_W-1:0] o_iss_v2,
  output logic [CW-1:0]           o_free_count
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            r_r1;
  logic [DEPTH-1:0]            r_r2;
  logic [DATA_W-1:0]           r_v1 [DEPTH];
  logic [DATA_W-1:0]           r_v2 [DEPTH];
  logic [TAG_W-1:0]            r_q1 [DEPTH];
  logic [TAG_W-1:0]            r_q2 [DEPTH];
  logic [TAG_W-1:0]            r_dst [DEPTH];
  logic [OP_W-1:0]             r_op [DEPTH];
  // r_age[j][i] set: entry j is older than entry i
  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  logic [CW-1:0]     w_cnt;
  logic              w_enq_fire;
  logic              w_hit;
  logic [ENQ_W-1:0]  w_alloc;
  logic [IW-1:0]     w_aidx [ENQ_W];
  logic [DEPTH-1:0]  w_new;
  logic [ENQ_W-1:0]  w_er1;
  logic [ENQ_W-1:0]  w_er2;
  logic [DATA_W-1:0] w_ev1 [ENQ_W];
  logic [DATA_W-1:0] w_ev2 [ENQ_W];
  logic [DEPTH-1:0]  w_wk1;
  logic [DEPTH-1:0]  w_wk2;
  logic [DATA_W-1:0] w_wv1 [DEPTH];
  logic [DATA_W-1:0] w_wv2 [DEPTH];
  logic [DEPTH-1:0]  w_rdy;
  logic [DEPTH-1:0]  w_cand;
  logic [DEPTH-1:0]  w_freed;
  logic [DEPTH-1:0]  w_sel [ISS_W];
  logic [IW-1:0]     w_sidx [ISS_W];
  logic [ISS_W-1:0]  w_iss_v;
  logic              w_old;
  logic              w_got;

  // occupancy from registered valid bits only
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_cnt = w_cnt + CW'(r_valid[i]);
  end

  assign o_free_count = CW'(DEPTH) - w_cnt;
  assign o_enq_ready  = o_free_count >= CW'(ENQ_W);
  assign w_enq_fire   = o_enq_ready & ~i_flush;
  assign w_rdy        = r_valid & r_r1 & r_r2;
  assign o_iss_valid  = w_iss_v;

  // lanes take the lowest free entries in lane order
  always_comb begin
    w_new   = '0;
    w_alloc = '0;
    w_hit   = 1'b0;
    for (int l = 0; l < ENQ_W; l++)
      w_aidx[l] = '0;
    for (int l = 0; l < ENQ_W; l++) begin
      w_hit = 1'b0;
      if (w_enq_fire && i_enq_valid[l]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!w_hit && !r_valid[i] && !w_new[i]) begin
            w_hit     = 1'b1;
            w_aidx[l] = IW'(i);
          end
        end
      end
      if (w_hit) begin
        w_alloc[l]        = 1'b1;
        w_new[w_aidx[l]]  = 1'b1;
      end
    end
  end

  // same-cycle CDB forwarding into enqueuing operands
  always_comb begin
    for (int l = 0; l < ENQ_W; l++) begin
      w_ev1[l] = i_enq_v1[l*DATA_W +: DATA_W];
      w_ev2[l] = i_enq_v2[l*DATA_W +: DATA_W];
      w_er1[l] = i_enq_r1[l];
      w_er2[l] = i_enq_r2[l];
      for (int c = 0; c < CDB_W; c++) begin
        if (i_cdb_valid[c]) begin
          if (!i_enq_r1[l] &&
              i_cdb_tag[c*TAG_W +: TAG_W] == i_enq_q1[l*TAG_W +: TAG_W]) begin
            w_ev1[l] = i_cdb_value[c*DATA_W +: DATA_W];
            w_er1[l] = 1'b1;
          end
          if (!i_enq_r2[l] &&
              i_cdb_tag[c*TAG_W +: TAG_W] == i_enq_q2[l*TAG_W +: TAG_W]) begin
            w_ev2[l] = i_cdb_value[c*DATA_W +: DATA_W];
            w_er2[l] = 1'b1;
          end
        end
      end
    end
  end

  // tag match per stored entry; later CDB lanes override earlier ones
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = 1'b0;
      w_wk2[i] = 1'b0;
      w_wv1[i] = r_v1[i];
      w_wv2[i] = r_v2[i];
      for (int c = 0; c < CDB_W; c++) begin
        if (i_cdb_valid[c] && i_cdb_tag[c*TAG_W +: TAG_W] == r_q1[i]) begin
          w_wk1[i] = 1'b1;
          w_wv1[i] = i_cdb_value[c*DATA_W +: DATA_W];
        end
        if (i_cdb_valid[c] && i_cdb_tag[c*TAG_W +: TAG_W] == r_q2[i]) begin
          w_wk2[i] = 1'b1;
          w_wv2[i] = i_cdb_value[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // oldest-first select; each port skips entries taken by lower ports
  always_comb begin
    w_cand  = w_rdy;
    w_freed = '0;
    w_old   = 1'b0;
    w_got   = 1'b0;
    for (int p = 0; p < ISS_W; p++) begin
      w_sel[p]  = '0;
      w_sidx[p] = '0;
      w_got     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_cand[i] && !w_got) begin
          w_old = 1'b0;
          for (int j = 0; j < DEPTH; j++)
            if (w_cand[j] && r_age[j][i]) w_old = 1'b1;
          if (!w_old) begin
            w_got     = 1'b1;
            w_sel[p]  = '0;
            w_sel[p][i] = 1'b1;
            w_sidx[p] = IW'(i);
          end
        end
      end
      w_iss_v[p] = w_got;
      if (w_got && i_iss_ready[p]) w_freed = w_freed | w_sel[p];
      w_cand = w_cand & ~w_sel[p];
    end
  end

  // issue port payload mux
  always_comb begin
    o_iss_op  = '0;
    o_iss_dst = '0;
    o_iss_v1  = '0;
    o_iss_v2  = '0;
    for (int p = 0; p < ISS_W; p++) begin
      o_iss_op[p*OP_W +: OP_W]      = r_op[w_sidx[p]];
      o_iss_dst[p*TAG_W +: TAG_W]   = r_dst[w_sidx[p]];
      o_iss_v1[p*DATA_W +: DATA_W]  = r_v1[w_sidx[p]];
      o_iss_v2[p*DATA_W +: DATA_W]  = r_v2[w_sidx[p]];
    end
  end

  // entry occupancy: flush wins over issue and enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else              r_valid <= (r_valid & ~w_freed) | w_new;
  end

  // new entries are younger than all live ones; lower lanes older
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (i_flush) begin
      r_age <= '0;
    end else begin
      for (int l = 0; l < ENQ_W; l++) begin
        if (w_alloc[l]) begin
          for (int j = 0; j < DEPTH; j++)
            r_age[j][w_aidx[l]] <= r_valid[j];
          r_age[w_aidx[l]] <= '0;
          for (int k = 0; k < l; k++)
            if (w_alloc[k]) r_age[w_aidx[k]][w_aidx[l]] <= 1'b1;
        end
      end
    end
  end

  // payload and operand state, qualified by r_valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && !r_r1[i] && w_wk1[i]) begin
        r_v1[i] <= w_wv1[i];
        r_r1[i] <= 1'b1;
      end
      if (r_valid[i] && !r_r2[i] && w_wk2[i]) begin
        r_v2[i] <= w_wv2[i];
        r_r2[i] <= 1'b1;
      end
    end
    for (int l = 0; l < ENQ_W; l++) begin
      if (w_alloc[l]) begin
        r_op[w_aidx[l]]  <= i_enq_op[l*OP_W +: OP_W];
        r_dst[w_aidx[l]] <= i_enq_dst[l*TAG_W +: TAG_W];
        r_q1[w_aidx[l]]  <= i_enq_q1[l*TAG_W +: TAG_W];
        r_q2[w_aidx[l]]  <= i_enq_q2[l*TAG_W +: TAG_W];
        r_v1[w_aidx[l]]  <= w_ev1[l];
        r_v2[w_aidx[l]]  <= w_ev2[l];
        r_r1[w_aidx[l]]  <= w_er1[l];
        r_r2[w_aidx[l]]  <= w_er2[l];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_age.sv
// Bench for issue_queue_age: vector table plus
// forwarding, wakeup, duplicate-tag and async-reset sequences.
module tb_issue_queue_age;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_flush;
  logic [1:0]    i_enq_valid;
  logic          o_enq_ready;
  logic [63:0]   i_enq_op;
  logic [11:0]   i_enq_dst;
  logic [63:0]   i_enq_v1;
  logic [63:0]   i_enq_v2;
  logic [11:0]   i_enq_q1;
  logic [11:0]   i_enq_q2;
  logic [1:0]    i_enq_r1;
  logic [1:0]    i_enq_r2;
  logic [3:0]    i_cdb_valid;
  logic [23:0]   i_cdb_tag;
  logic [127:0]  i_cdb_value;
  logic [1:0]    o_iss_valid;
  logic [1:0]    i_iss_ready;
  logic [63:0]   o_iss_op;
  logic [11:0]   o_iss_dst;
  logic [63:0]   o_iss_v1;
  logic [63:0]   o_iss_v2;
  logic [3:0]    o_free_count;

  always #5 clk = ~clk;

  issue_queue_age dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
    .i_enq_op(i_enq_op), .i_enq_dst(i_enq_dst),
    .i_enq_v1(i_enq_v1), .i_enq_v2(i_enq_v2),
    .i_enq_q1(i_enq_q1), .i_enq_q2(i_enq_q2),
    .i_enq_r1(i_enq_r1), .i_enq_r2(i_enq_r2),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
    .i_cdb_value(i_cdb_value),
    .o_iss_valid(o_iss_valid), .i_iss_ready(i_iss_ready),
    .o_iss_op(o_iss_op), .o_iss_dst(o_iss_dst),
    .o_iss_v1(o_iss_v1), .o_iss_v2(o_iss_v2),
    .o_free_count(o_free_count)
  );

  typedef struct {
    logic [31:0] op;
    logic [5:0]  dst;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  typedef struct {
    logic [1:0] ev;
    logic [1:0] ir;
    logic       fl;
    logic [3:0] xf;
    logic       xr;
    logic [1:0] xiv;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[16];
  int   n_chk = 0;
  int   n_fail = 0;
  int   seq = 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  task automatic idle();
    i_flush     = 1'b0;
    i_enq_valid = '0;
    i_enq_op    = '0;
    i_enq_dst   = '0;
    i_enq_v1    = '0;
    i_enq_v2    = '0;
    i_enq_q1    = '0;
    i_enq_q2    = '0;
    i_enq_r1    = '0;
    i_enq_r2    = '0;
    i_cdb_valid = '0;
    i_cdb_tag   = '0;
    i_cdb_value = '0;
    i_iss_ready = '0;
  endtask

  function automatic exp_t mk(input int s);
    exp_t e;
    e.op  = 32'hA000_0000 | 32'(s);
    e.dst = 6'(s);
    e.v1  = 32'h1000 + 32'(s);
    e.v2  = 32'h2000 + 32'(s);
    return e;
  endfunction

  task automatic drive_lane(input int l, input exp_t e,
                            input logic r1, input logic r2,
                            input logic [5:0] q1, input logic [5:0] q2);
    i_enq_valid[l]          = 1'b1;
    i_enq_op[l*OW +: OW]    = e.op;
    i_enq_dst[l*TW +: TW]   = e.dst;
    i_enq_v1[l*DW +: DW]    = e.v1;
    i_enq_v2[l*DW +: DW]    = e.v2;
    i_enq_q1[l*TW +: TW]    = q1;
    i_enq_q2[l*TW +: TW]    = q2;
    i_enq_r1[l]             = r1;
    i_enq_r2[l]             = r2;
  endtask

  task automatic cdb(input int c, input logic [5:0] t,
                     input logic [31:0] v);
    i_cdb_valid[c]         = 1'b1;
    i_cdb_tag[c*TW +: TW]  = t;
    i_cdb_value[c*DW +: DW] = v;
  endtask

  task automatic check_port(input int p, input exp_t e);
    chk($sformatf("p%0d_op", p),  64'(o_iss_op[p*OW +: OW]),  64'(e.op));
    chk($sformatf("p%0d_dst", p), 64'(o_iss_dst[p*TW +: TW]), 64'(e.dst));
    chk($sformatf("p%0d_v1", p),  64'(o_iss_v1[p*DW +: DW]),  64'(e.v1));
    chk($sformatf("p%0d_v2", p),  64'(o_iss_v2[p*DW +: DW]),  64'(e.v2));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t nw[2];
    exp_t e;
    int   npop;

    //       ev     ir     fl    xf     xr    xiv
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 4'd8, 1'b1, 2'b00};
    tbl[1]  = '{2'b00, 2'b11, 1'b0, 4'd6, 1'b1, 2'b11};
    tbl[2]  = '{2'b00, 2'b00, 1'b0, 4'd8, 1'b1, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 1'b0, 4'd8, 1'b1, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 4'd6, 1'b1, 2'b11};
    tbl[5]  = '{2'b11, 2'b00, 1'b0, 4'd4, 1'b1, 2'b11};
    tbl[6]  = '{2'b01, 2'b00, 1'b0, 4'd2, 1'b1, 2'b11};
    tbl[7]  = '{2'b11, 2'b00, 1'b0, 4'd1, 1'b0, 2'b11};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 4'd1, 1'b0, 2'b11};
    tbl[9]  = '{2'b00, 2'b01, 1'b0, 4'd1, 1'b0, 2'b11};
    tbl[10] = '{2'b00, 2'b11, 1'b0, 4'd2, 1'b1, 2'b11};
    tbl[11] = '{2'b00, 2'b01, 1'b0, 4'd4, 1'b1, 2'b11};
    tbl[12] = '{2'b00, 2'b00, 1'b0, 4'd5, 1'b1, 2'b11};
    tbl[13] = '{2'b00, 2'b00, 1'b0, 4'd5, 1'b1, 2'b11};
    tbl[14] = '{2'b11, 2'b11, 1'b1, 4'd5, 1'b1, 2'b11};
    tbl[15] = '{2'b00, 2'b00, 1'b0, 4'd8, 1'b1, 2'b00};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      idle();
      for (int l = 0; l < 2; l++) begin
        nw[l] = mk(seq);
        seq++;
        if (tbl[k].ev[l]) drive_lane(l, nw[l], 1'b1, 1'b1, 6'd0, 6'd0);
      end
      i_iss_ready = tbl[k].ir;
      i_flush     = tbl[k].fl;
      @(negedge clk);
      chk($sformatf("v%0d_free", k), 64'(o_free_count), 64'(tbl[k].xf));
      chk($sformatf("v%0d_rdy", k),  64'(o_enq_ready),  64'(tbl[k].xr));
      chk($sformatf("v%0d_iv", k),   64'(o_iss_valid),  64'(tbl[k].xiv));
      npop = 0;
      for (int p = 0; p < 2; p++) begin
        if (tbl[k].xiv[p] && o_iss_valid[p]) begin
          if (sbq.size() > p) check_port(p, sbq[p]);
          else chk($sformatf("v%0d_sb_empty", k), 64'(sbq.size()), 64'(p + 1));
          if (tbl[k].ir[p]) npop++;
        end
      end
      for (int n = 0; n < npop; n++)
        if (sbq.size() > 0) void'(sbq.pop_front());
      if (tbl[k].fl) sbq.delete();
      else if (tbl[k].xr)
        for (int l = 0; l < 2; l++)
          if (tbl[k].ev[l]) sbq.push_back(nw[l]);
      tick();
    end

    // enqueue-time forwarding (C) and a waiting entry (D)
    idle();
    nw[0] = mk(100);
    nw[0].v1 = 32'h0;
    nw[1] = mk(101);
    nw[1].v1 = 32'h77;
    drive_lane(0, nw[0], 1'b0, 1'b1, 6'd5, 6'd0);
    drive_lane(1, nw[1], 1'b1, 1'b0, 6'd9, 6'd9);
    cdb(2, 6'd5, 32'hDEAD);
    e = nw[0];
    e.v1 = 32'hDEAD;
    sbq.push_back(e);
    @(negedge clk);
    chk("fwd_pre_iv", 64'(o_iss_valid), 64'b00);
    tick();
    idle();
    i_iss_ready = 2'b01;
    @(negedge clk);
    chk("fwd_iv", 64'(o_iss_valid), 64'b01);
    if (sbq.size() > 0) check_port(0, sbq.pop_front());
    else chk("fwd_sb_empty", 64'(sbq.size()), 64'd1);
    tick();

    // wakeup on duplicate tag 9: highest CDB lane supplies the value
    idle();
    cdb(0, 6'd9, 32'h111);
    cdb(3, 6'd9, 32'h999);
    e = nw[1];
    e.v2 = 32'h999;
    sbq.push_back(e);
    @(negedge clk);
    chk("wake_same_iv", 64'(o_iss_valid), 64'b00);
    chk("wake_same_free", 64'(o_free_count), 64'd7);
    tick();
    idle();
    i_iss_ready = 2'b01;
    @(negedge clk);
    chk("wake_next_iv", 64'(o_iss_valid), 64'b01);
    if (sbq.size() > 0) check_port(0, sbq.pop_front());
    else chk("wake_sb_empty", 64'(sbq.size()), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("wake_free", 64'(o_free_count), 64'd8);
    chk("wake_iv_after", 64'(o_iss_valid), 64'b00);

    // asynchronous reset between edges
    tick();
    drive_lane(0, mk(200), 1'b1, 1'b1, 6'd0, 6'd0);
    drive_lane(1, mk(201), 1'b1, 1'b1, 6'd0, 6'd0);
    tick();
    idle();
    #1;
    chk("arst_pre_free", 64'(o_free_count), 64'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_free", 64'(o_free_count), 64'd8);
    chk("arst_rdy", 64'(o_enq_ready), 64'd1);
    chk("arst_iv", 64'(o_iss_valid), 64'b00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("arst_post_free", 64'(o_free_count), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
